// File: rtl/vend_output_sequencer.sv
// Vending machine output sequencer: drives the product dispense pulse, meters
// out change one nickel at a time against a hopper acknowledge, and latches a
// fault if the hopper stops answering. All state updates on the falling edge.
module vend_output_sequencer #(
    parameter int DISP_CYCLES = 4,   // dispense pulse length in clocks (1..15)
    parameter int ACK_TIMEOUT = 15   // max clocks to wait for a hopper ack (1..15)
) (
    input  logic       DCLK,
    input  logic       DRES,
    input  logic [3:0] current_s,
    input  logic       chg_ack,
    output logic       dispense,
    output logic       chg_req,
    output logic [2:0] chg_left,
    output logic       vend_done,
    output logic       busy,
    output logic       fault
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DISP  = 3'd1;
    localparam logic [2:0] S_CREQ  = 3'd2;
    localparam logic [2:0] S_CWAIT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    localparam logic [3:0] DISP_LOAD = 4'(DISP_CYCLES);
    localparam logic [3:0] TMO_LOAD  = 4'(ACK_TIMEOUT);

    logic [2:0] r_state;
    logic [2:0] w_state_nx;
    logic [3:0] r_cnt;       // shared down-counter: dispense length, then ack timeout
    logic [3:0] w_cnt_nx;
    logic [2:0] r_left;      // nickels still owed, latched at vend start
    logic [2:0] w_left_nx;
    logic       r_s3;        // previous sample of the vend-request bit
    logic       w_start;

    // A vend start is a sampled rising edge of the request bit; a level held
    // high across a transaction therefore never retriggers.
    assign w_start = current_s[3] & ~r_s3;

    // Next-state, counter and change-owed computation.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_left_nx  = r_left;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nx = S_DISP;
                    w_cnt_nx   = DISP_LOAD;
                    w_left_nx  = current_s[2:0];
                end
            end
            S_DISP: begin
                if (r_cnt <= 4'd1) begin
                    w_cnt_nx   = 4'd0;
                    w_state_nx = (r_left != 3'd0) ? S_CREQ : S_DONE;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            S_CREQ: begin
                w_state_nx = S_CWAIT;
                w_cnt_nx   = TMO_LOAD;
            end
            S_CWAIT: begin
                // An ack on the same edge the timeout expires wins.
                if (chg_ack) begin
                    w_cnt_nx   = 4'd0;
                    w_left_nx  = (r_left != 3'd0) ? r_left - 3'd1 : 3'd0;
                    w_state_nx = (r_left > 3'd1) ? S_CREQ : S_DONE;
                end else if (r_cnt <= 4'd1) begin
                    w_cnt_nx   = 4'd0;
                    w_state_nx = S_FAULT;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            S_FAULT: begin
                // Sticky until reset; unpaid count stays visible.
                w_state_nx = S_FAULT;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = 4'd0;
                w_left_nx  = 3'd0;
            end
        endcase
    end

    // State, counter and request-bit history registers.
    always_ff @(negedge DCLK or negedge DRES) begin
        if (!DRES) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_left  <= 3'd0;
            r_s3    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_left  <= w_left_nx;
            r_s3    <= current_s[3];
        end
    end

    // Outputs are registered from the next-state decode so they line up with
    // the state they describe without any input-to-output path.
    always_ff @(negedge DCLK or negedge DRES) begin
        if (!DRES) begin
            dispense  <= 1'b0;
            chg_req   <= 1'b0;
            vend_done <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            dispense  <= (w_state_nx == S_DISP);
            chg_req   <= (w_state_nx == S_CREQ);
            vend_done <= (w_state_nx == S_DONE);
            busy      <= (w_state_nx != S_IDLE);
            fault     <= (w_state_nx == S_FAULT);
        end
    end

    assign chg_left = r_left;

endmodule

// File: tb/tb_vend_output_sequencer.sv
// Scoreboard bench for vend_output_sequencer. Each vend transaction is laid
// out as a timeline of expected per-clock outputs (dispense run, one request
// per nickel, wait gap, done pulse) and queued; a monitor pops one entry per
// clock and compares.
module tb_vend_output_sequencer;

    localparam int DISP = 4;
    localparam int TMO  = 15;

    typedef struct packed {
        logic       disp;
        logic       creq;
        logic [2:0] left;
        logic       done;
        logic       busy;
        logic       fault;
    } exp_t;

    typedef int dly_t [7];

    logic       DCLK = 1'b0;
    logic       DRES = 1'b0;
    logic [3:0] current_s = 4'd0;
    logic       chg_ack = 1'b0;
    logic       dispense, chg_req, vend_done, busy, fault;
    logic [2:0] chg_left;

    int   checks = 0;
    int   errors = 0;
    int   nsamp  = 0;
    bit   s_all_ones = 1'b0;   // force current_s=1111 during busy phases
    exp_t expq[$];

    localparam exp_t IDLE = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};

    vend_output_sequencer #(.DISP_CYCLES(DISP), .ACK_TIMEOUT(TMO)) dut (
        .DCLK(DCLK), .DRES(DRES), .current_s(current_s), .chg_ack(chg_ack),
        .dispense(dispense), .chg_req(chg_req), .chg_left(chg_left),
        .vend_done(vend_done), .busy(busy), .fault(fault)
    );

    always #5 DCLK = ~DCLK;

    function automatic exp_t mk(input logic d, input logic r, input logic [2:0] l,
                                input logic v, input logic b, input logic f);
        exp_t e;
        e = '{d, r, l, v, b, f};
        return e;
    endfunction

    function automatic exp_t act();
        exp_t a;
        a = '{dispense, chg_req, chg_left, vend_done, busy, fault};
        return a;
    endfunction

    function automatic logic ra();
        return 1'($urandom);
    endfunction

    function automatic logic [3:0] rs();
        return s_all_ones ? 4'hF : 4'($urandom);
    endfunction

    task automatic chk(input string name, input exp_t a, input exp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got disp=%b req=%b left=%0d done=%b busy=%b fault=%b, expected disp=%b req=%b left=%0d done=%b busy=%b fault=%b",
                     name, a.disp, a.creq, a.left, a.done, a.busy, a.fault,
                     e.disp, e.creq, e.left, e.done, e.busy, e.fault);
        end
    endtask

    // Monitor: one expected entry per clock, sampled on the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge DCLK);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                nsamp++;
                chk($sformatf("out@%0d", nsamp), act(), e);
            end
        end
    end

    // Drive one clock of inputs and queue the outputs expected after the next falling edge.
    task automatic step(input logic [3:0] s, input logic ack, input logic rst_n, input exp_t e);
        @(posedge DCLK);
        #1;
        DRES      = rst_n;
        current_s = s;
        chg_ack   = ack;
        expq.push_back(e);
    endtask

    // Asynchronous reset mid-cycle, held for n clocks.
    task automatic reset_pulse(input int n);
        @(posedge DCLK);
        #3;
        DRES = 1'b0;
        #1;
        chk("async_reset", act(), IDLE);
        expq.push_back(IDLE);
        for (int i = 1; i < n; i++) step(4'($urandom), ra(), 1'b0, IDLE);
    endtask

    // One vend transaction owing c nickels. dly[i] is the number of wait clocks
    // before the hopper acks nickel i (1..15); 0 means the hopper never acks.
    task automatic vend(input logic [2:0] c, input dly_t dly, input bit after_reset,
                        input int tail, output bit faulted);
        logic [2:0] left;
        bit         need_ack;
        int         idx;
        left     = c;
        need_ack = 1'b0;
        idx      = 0;
        faulted  = 1'b0;
        if (!after_reset) step({1'b0, 3'($urandom)}, ra(), 1'b1, IDLE);
        step({1'b1, c}, ra(), 1'b1, mk(1, 0, c, 0, 1, 0));
        for (int k = 1; k < DISP; k++) step(rs(), ra(), 1'b1, mk(1, 0, c, 0, 1, 0));
        while (left != 3'd0 && !faulted) begin
            step(rs(), need_ack ? 1'b1 : ra(), 1'b1, mk(0, 1, left, 0, 1, 0));
            if (dly[idx] == 0) begin
                for (int w = 1; w <= TMO; w++)
                    step(rs(), (w == 1) ? ra() : 1'b0, 1'b1, mk(0, 0, left, 0, 1, 0));
                for (int f = 0; f < 4; f++)
                    step(rs(), (f == 0) ? 1'b0 : ra(), 1'b1, mk(0, 0, left, 0, 1, 1));
                faulted = 1'b1;
            end else begin
                for (int w = 1; w <= dly[idx]; w++)
                    step(rs(), (w == 1) ? ra() : 1'b0, 1'b1, mk(0, 0, left, 0, 1, 0));
                need_ack = 1'b1;
                left     = left - 3'd1;
                idx++;
            end
        end
        if (!faulted) begin
            step({1'b1, 3'($urandom)}, need_ack ? 1'b1 : ra(), 1'b1, mk(0, 0, 0, 1, 1, 0));
            step({1'b1, 3'($urandom)}, ra(), 1'b1, IDLE);
            // Request bit held high after completion must not restart.
            for (int t = 0; t < tail; t++) step({1'b1, 3'($urandom)}, ra(), 1'b1, IDLE);
        end
    endtask

    initial begin
        bit   flt;
        dly_t rd;

        // Reset state before any clock edge, then held through two edges with the request bit high.
        #1;
        chk("reset_state", act(), IDLE);
        step(4'b1011, 1'b1, 1'b0, IDLE);
        step(4'b1111, 1'b0, 1'b0, IDLE);
        step(4'b0000, 1'b0, 1'b1, IDLE);

        // No change owed: dispense only, then done.
        vend(3'd0, '{1, 1, 1, 1, 1, 1, 1}, 1'b0, 2, flt);

        // Three nickels, each acked 2 clocks after its request.
        vend(3'd3, '{1, 1, 1, 1, 1, 1, 1}, 1'b0, 2, flt);

        // Hopper never answers: fault with two nickels unpaid, held until reset.
        vend(3'd2, '{0, 0, 0, 0, 0, 0, 0}, 1'b0, 0, flt);
        reset_pulse(2);

        // Request already high at reset release starts immediately; ack on the last allowed wait clock.
        vend(3'd1, '{15, 15, 15, 15, 15, 15, 15}, 1'b1, 2, flt);

        // current_s forced to 1111 throughout a 1001 vend: one nickel only, no retrigger.
        s_all_ones = 1'b1;
        vend(3'd1, '{3, 3, 3, 3, 3, 3, 3}, 1'b0, 4, flt);
        s_all_ones = 1'b0;

        // Reset mid-dispense aborts with no done pulse.
        step(4'b0000, 1'b0, 1'b1, IDLE);
        step(4'b1101, 1'b0, 1'b1, mk(1, 0, 3'd5, 0, 1, 0));
        step(4'b1101, 1'b1, 1'b1, mk(1, 0, 3'd5, 0, 1, 0));
        reset_pulse(3);
        step(4'b0000, 1'b0, 1'b1, IDLE);
        step(4'b0000, 1'b0, 1'b1, IDLE);

        // Randomized transactions.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 7; i++)
                rd[i] = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 15));
            vend(3'($urandom), rd, 1'b0, int'($urandom_range(0, 3)), flt);
            if (flt) reset_pulse(int'($urandom_range(1, 3)));
        end

        step(4'b0000, 1'b0, 1'b1, IDLE);
        @(posedge DCLK);
        #2;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
